// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receiver/transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    // 50 MHz / 19200 baud
    localparam int DEF_BAUD_DIV = 2604;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Loadable baud down-counter; tick is high while the count is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CNT_W = $clog2(uart_pkg::DEF_BAUD_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rcv_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rcv_param
//  Description : Parametrised UART receiver with parity, framing and overrun
//                checks, delivering words through a rdy/clr_rdy handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rcv_param
    import uart_pkg::*;
#(
    parameter int      DATA_W   = 8,
    parameter int      BAUD_DIV = DEF_BAUD_DIV,
    parameter parity_t PARITY   = PAR_NONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic              clr_rdy,
    output logic              rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              frm_err,
    output logic              par_err,
    output logic              ovr_err,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_half   = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_full   = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] c_last   = BIT_W'(DATA_W - 1);
    localparam logic             c_par_en = (PARITY != PAR_NONE);

    rx_state_t          r_state;
    rx_state_t          w_next;
    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic               w_start_det;
    logic               w_tick;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par_acc;
    logic               r_par_err_n;
    logic               r_done;
    logic               r_rdy;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_frm_err;
    logic               r_par_err;
    logic               r_ovr_err;

    // Preset high so leaving reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= RX;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_start_det = r_rx_prev & ~r_rx_s;

    uart_baud_cnt #(
        .CNT_W    (CNT_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_det) w_next = START;
            START:   if (w_tick) w_next = r_rx_s ? IDLE : DATA;
            DATA:    if (w_tick && (r_bit_cnt == c_last)) w_next = c_par_en ? PAR : STOP;
            PAR:     if (w_tick) w_next = STOP;
            STOP:    if (r_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        w_load     = 1'b0;
        w_load_val = c_full;
        if (r_state == IDLE) begin
            w_load     = w_start_det;
            w_load_val = c_half;
        end else begin
            w_load     = w_tick;
        end
    end

    // r_done holds STOP for one extra cycle so rdy rises the edge after the stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err_n <= 1'b0;
            r_done      <= 1'b0;
            r_rx_data   <= '0;
            r_frm_err   <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && w_tick && !r_done;
            case (r_state)
                START: begin
                    if (w_tick) begin
                        r_bit_cnt   <= '0;
                        r_par_acc   <= 1'b0;
                        r_par_err_n <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {r_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        r_par_acc <= r_par_acc ^ r_rx_s;
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_par_err_n <= (PARITY == PAR_ODD) ? ~(r_par_acc ^ r_rx_s)
                                                           :  (r_par_acc ^ r_rx_s);
                    end
                end
                STOP: begin
                    if (w_tick && !r_done) begin
                        r_rx_data <= r_shift;
                        r_frm_err <= ~r_rx_s;
                        r_par_err <= c_par_en & r_par_err_n;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion beats a coincident clr_rdy; overrun looks at the registered rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_ovr_err <= 1'b0;
        end else if (r_done) begin
            r_rdy     <= 1'b1;
            r_ovr_err <= r_ovr_err | r_rdy;
        end else if (clr_rdy) begin
            r_rdy     <= 1'b0;
            r_ovr_err <= 1'b0;
        end
    end

    assign rdy     = r_rdy;
    assign rx_data = r_rx_data;
    assign frm_err = r_frm_err;
    assign par_err = r_par_err;
    assign ovr_err = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rcv_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rcv_param
//  Description : Directed self-checking bench for uart_rcv_param (BAUD_DIV=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rcv_param;
    import uart_pkg::*;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_ab = 1'b0;
    logic       rst_c  = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

    logic       rdy_a, frm_a, par_a, ovr_a, busy_a;
    logic [7:0] data_a;
    logic       rdy_b, frm_b, par_b, ovr_b, busy_b;
    logic [7:0] data_b;
    logic       rdy_c, frm_c, par_c, ovr_c, busy_c;
    logic [8:0] data_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rcv_param #(.DATA_W(8), .BAUD_DIV(BD), .PARITY(PAR_NONE)) u_dut_a (
        .clk(clk), .rst_n(rst_ab), .RX(rx_a), .clr_rdy(clr_a), .rdy(rdy_a),
        .rx_data(data_a), .frm_err(frm_a), .par_err(par_a), .ovr_err(ovr_a), .busy(busy_a));

    uart_rcv_param #(.DATA_W(8), .BAUD_DIV(BD), .PARITY(PAR_EVEN)) u_dut_b (
        .clk(clk), .rst_n(rst_ab), .RX(rx_b), .clr_rdy(clr_b), .rdy(rdy_b),
        .rx_data(data_b), .frm_err(frm_b), .par_err(par_b), .ovr_err(ovr_b), .busy(busy_b));

    uart_rcv_param #(.DATA_W(9), .BAUD_DIV(BD), .PARITY(PAR_ODD)) u_dut_c (
        .clk(clk), .rst_n(rst_c), .RX(rx_c), .clr_rdy(clr_c), .rdy(rdy_c),
        .rx_data(data_c), .frm_err(frm_c), .par_err(par_c), .ovr_err(ovr_c), .busy(busy_c));

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic pulse_clr(input int sel);
        @(negedge clk);
        case (sel)
            0:       clr_a = 1'b1;
            1:       clr_b = 1'b1;
            default: clr_c = 1'b1;
        endcase
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;
    endtask

    // pmode: 0 none, 1 even, 2 odd; the stop level is left on the line afterwards
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int pmode, input logic pflip, input logic stop);
        logic p;
        p = 1'b0;
        @(negedge clk);
        set_rx(sel, 1'b0);
        repeat (BD) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, data[i]);
            p = p ^ data[i];
            repeat (BD) @(negedge clk);
        end
        if (pmode != 0) begin
            set_rx(sel, ((pmode == 2) ? ~p : p) ^ pflip);
            repeat (BD) @(negedge clk);
        end
        set_rx(sel, stop);
        repeat (BD) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
        checks++; if (frm_a !== 1'b0) begin errors++; $display("FAIL reset_frm: got %b want 0", frm_a); end
        checks++; if (par_a !== 1'b0) begin errors++; $display("FAIL reset_par: got %b want 0", par_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_8n1;
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        fork
            send_frame(0, 9'h06A, 8, 0, 1'b0, 1'b1);
            begin
                wait (rx_a == 1'b0);
                while (n < 300 && !seen) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (rdy_a) seen = 1'b1;
                end
            end
        join
        // n counts the capturing edge of the fall too
        checks++; if (n - 1 != 9 * BD + BD / 2 + 3) begin errors++; $display("FAIL 8n1_latency: got %0d want %0d", n - 1, 9 * BD + BD / 2 + 3); end
        checks++; if (data_a !== 8'h6A) begin errors++; $display("FAIL 8n1_data: got %h want 6a", data_a); end
        checks++; if ({frm_a, par_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL 8n1_errs: got %b want 000", {frm_a, par_a, ovr_a}); end
        pulse_clr(0);
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL 8n1_clr: got %b want 0", rdy_a); end
    endtask

    task automatic test_parity;
        send_frame(1, 9'h0A5, 8, 1, 1'b0, 1'b1);
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL par_ok_rdy: got %b want 1", rdy_b); end
        checks++; if (data_b !== 8'hA5) begin errors++; $display("FAIL par_ok_data: got %h want a5", data_b); end
        checks++; if (par_b !== 1'b0) begin errors++; $display("FAIL par_ok_err: got %b want 0", par_b); end
        pulse_clr(1);
        send_frame(1, 9'h0A5, 8, 1, 1'b1, 1'b1);
        checks++; if (par_b !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %b want 1", par_b); end
        checks++; if (data_b !== 8'hA5) begin errors++; $display("FAIL par_bad_data: got %h want a5", data_b); end
        checks++; if (frm_b !== 1'b0) begin errors++; $display("FAIL par_bad_frm: got %b want 0", frm_b); end
        pulse_clr(1);
        checks++; if (par_b !== 1'b1) begin errors++; $display("FAIL par_hold: got %b want 1", par_b); end
    endtask

    task automatic test_framing;
        bit saw;
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0);
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL frm_rdy: got %b want 1", rdy_a); end
        checks++; if (frm_a !== 1'b1) begin errors++; $display("FAIL frm_err: got %b want 1", frm_a); end
        checks++; if (data_a !== 8'h3C) begin errors++; $display("FAIL frm_data: got %h want 3c", data_a); end
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy_a) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", saw); end
        pulse_clr(0);
        checks++; if (frm_a !== 1'b1) begin errors++; $display("FAIL frm_hold: got %b want 1", frm_a); end
        set_rx(0, 1'b1);
        repeat (20) @(negedge clk);
        send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1);
        checks++; if (data_a !== 8'h55) begin errors++; $display("FAIL break_data: got %h want 55", data_a); end
        checks++; if (frm_a !== 1'b0) begin errors++; $display("FAIL break_frm: got %b want 0", frm_a); end
        pulse_clr(0);
    endtask

    task automatic test_back_to_back;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
        checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr_a); end
        checks++; if (data_a !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h want 22", data_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL ovr_rdy: got %b want 1", rdy_a); end
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL ovr_clr_rdy: got %b want 0", rdy_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clr_ovr: got %b want 0", ovr_a); end
    endtask

    task automatic test_glitch;
        bit saw;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a) saw = 1'b1;
        end
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", saw); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", rdy_a); end
        // clr_rdy coincident with the edge that raises rdy (fall + 155 clk)
        fork
            send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1);
            begin
                wait (rx_a == 1'b0);
                repeat (9 * BD + BD / 2 + 3) @(negedge clk);
                clr_a = 1'b1;
                @(negedge clk);
                clr_a = 1'b0;
            end
        join
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL clr_coincident_rdy: got %b want 1", rdy_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL clr_coincident_ovr: got %b want 0", ovr_a); end
        checks++; if (data_a !== 8'h5A) begin errors++; $display("FAIL clr_coincident_data: got %h want 5a", data_a); end
    endtask

    task automatic test_wide_odd_reset;
        send_frame(2, 9'h1F0, 9, 2, 1'b0, 1'b1);
        checks++; if (data_c !== 9'h1F0) begin errors++; $display("FAIL w9_data: got %h want 1f0", data_c); end
        checks++; if ({rdy_c, frm_c, par_c} !== 3'b100) begin errors++; $display("FAIL w9_flags: got %b want 100", {rdy_c, frm_c, par_c}); end
        fork
            send_frame(2, 9'h155, 9, 2, 1'b0, 1'b1);
            begin
                wait (rx_c == 1'b0);
                repeat (3 * BD) @(negedge clk);
                rst_c = 1'b0;
                #1;
                checks++; if ({rdy_c, busy_c, frm_c, par_c, ovr_c} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 00000", {rdy_c, busy_c, frm_c, par_c, ovr_c}); end
                checks++; if (data_c !== 9'h000) begin errors++; $display("FAIL rst_mid_data: got %h want 000", data_c); end
            end
        join
        @(negedge clk);
        rst_c = 1'b1;
        repeat (5 * BD) @(negedge clk);
        checks++; if ({rdy_c, busy_c} !== 2'b00) begin errors++; $display("FAIL rst_after: got %b want 00", {rdy_c, busy_c}); end
        send_frame(2, 9'h0AB, 9, 2, 1'b0, 1'b1);
        checks++; if (data_c !== 9'h0AB) begin errors++; $display("FAIL w9_after_data: got %h want 0ab", data_c); end
        checks++; if ({rdy_c, frm_c, par_c, ovr_c} !== 4'b1000) begin errors++; $display("FAIL w9_after_flags: got %b want 1000", {rdy_c, frm_c, par_c, ovr_c}); end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_back_to_back();
        test_glitch();
        test_wide_odd_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
